// File: rtl/lf_capture_sequencer_if.sv
// Pixel stream bundle between the pixel source, the capture sequencer and the filter.
// The master side drives source pixels and observes framed output; the slave side is the sequencer.
interface lf_capture_sequencer_if;
  logic        src_valid;
  logic [23:0] src_pixel;
  logic        src_ready;
  logic        pixel_valid_out;
  logic [23:0] pixel_out;
  logic        soc_out;
  logic        eoc_out;
  logic        solf_out;
  logic        eolf_out;
  logic [1:0]  kernel_size_out;
  logic [7:0]  capture_idx;

  modport master (
    output src_valid, src_pixel,
    input  src_ready, pixel_valid_out, pixel_out, soc_out, eoc_out,
           solf_out, eolf_out, kernel_size_out, capture_idx
  );

  modport slave (
    input  src_valid, src_pixel,
    output src_ready, pixel_valid_out, pixel_out, soc_out, eoc_out,
           solf_out, eolf_out, kernel_size_out, capture_idx
  );
endinterface

// File: rtl/lf_capture_sequencer.sv
// Frames a raw RGB pixel stream into captures and light fields for the low-pass filter,
// inserting an idle gap after each capture and freezing the kernel size per light field.
module lf_capture_sequencer #(
  parameter int IMG_W        = 640,
  parameter int IMG_H        = 480,
  parameter int NUM_CAPTURES = 17,
  parameter int GAP_CYCLES   = 16
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          start,
  input  logic [1:0]                    sw_kernel_size,
  lf_capture_sequencer_if.slave         px,
  output logic                          busy
);

  localparam int NUM_PIX = IMG_W * IMG_H;
  localparam int PIX_W   = (NUM_PIX > 1) ? $clog2(NUM_PIX) : 1;
  localparam int GAP_W   = $clog2(GAP_CYCLES + 1);

  localparam logic [PIX_W-1:0] LAST_PIX = PIX_W'(NUM_PIX - 1);
  localparam logic [GAP_W-1:0] LAST_GAP = GAP_W'(GAP_CYCLES - 1);
  localparam logic [7:0]       LAST_CAP = 8'(NUM_CAPTURES - 1);

  typedef enum logic [1:0] {
    IDLE,
    STREAM,
    GAP
  } state_t;

  state_t            state_q, state_d;
  logic [PIX_W-1:0]  pix_cnt_q, pix_cnt_d;
  logic [GAP_W-1:0]  gap_cnt_q, gap_cnt_d;
  logic [7:0]        cap_idx_q, cap_idx_d;
  logic [1:0]        kernel_q, kernel_d;
  logic              busy_q, busy_d;
  logic              src_ready_q, src_ready_d;
  logic              pixel_valid_q, pixel_valid_d;
  logic [23:0]       pixel_q, pixel_d;
  logic              soc_q, soc_d;
  logic              eoc_q, eoc_d;
  logic              solf_q, solf_d;
  logic              eolf_q, eolf_d;
  logic              handshake;
  logic              last_pix;

  assign handshake = src_ready_q & px.src_valid;
  assign last_pix  = (pix_cnt_q == LAST_PIX);

  // Markers and valid are one-shot; pixel data holds its last value between beats.
  always_comb begin
    state_d       = state_q;
    pix_cnt_d     = pix_cnt_q;
    gap_cnt_d     = gap_cnt_q;
    cap_idx_d     = cap_idx_q;
    kernel_d      = kernel_q;
    busy_d        = busy_q;
    src_ready_d   = src_ready_q;
    pixel_valid_d = 1'b0;
    pixel_d       = pixel_q;
    soc_d         = 1'b0;
    eoc_d         = 1'b0;
    solf_d        = 1'b0;
    eolf_d        = 1'b0;

    case (state_q)
      IDLE: begin
        if (start) begin
          state_d     = STREAM;
          kernel_d    = sw_kernel_size;
          pix_cnt_d   = '0;
          gap_cnt_d   = '0;
          cap_idx_d   = '0;
          busy_d      = 1'b1;
          src_ready_d = 1'b1;
        end
      end

      STREAM: begin
        if (handshake) begin
          pixel_valid_d = 1'b1;
          pixel_d       = px.src_pixel;
          soc_d         = (pix_cnt_q == '0);
          eoc_d         = last_pix;
          solf_d        = (pix_cnt_q == '0) && (cap_idx_q == '0);
          eolf_d        = last_pix && (cap_idx_q == LAST_CAP);
          if (last_pix) begin
            pix_cnt_d   = '0;
            gap_cnt_d   = '0;
            src_ready_d = 1'b0;
            state_d     = GAP;
          end else begin
            pix_cnt_d = pix_cnt_q + PIX_W'(1);
          end
        end
      end

      GAP: begin
        // Gap end decides between the next capture and the end of the light field.
        if (gap_cnt_q == LAST_GAP) begin
          gap_cnt_d = '0;
          if (cap_idx_q == LAST_CAP) begin
            state_d = IDLE;
            busy_d  = 1'b0;
          end else begin
            cap_idx_d   = cap_idx_q + 8'd1;
            src_ready_d = 1'b1;
            state_d     = STREAM;
          end
        end else begin
          gap_cnt_d = gap_cnt_q + GAP_W'(1);
        end
      end

      default: begin
        state_d     = IDLE;
        busy_d      = 1'b0;
        src_ready_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      pix_cnt_q     <= '0;
      gap_cnt_q     <= '0;
      cap_idx_q     <= '0;
      kernel_q      <= '0;
      busy_q        <= 1'b0;
      src_ready_q   <= 1'b0;
      pixel_valid_q <= 1'b0;
      pixel_q       <= '0;
      soc_q         <= 1'b0;
      eoc_q         <= 1'b0;
      solf_q        <= 1'b0;
      eolf_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      pix_cnt_q     <= pix_cnt_d;
      gap_cnt_q     <= gap_cnt_d;
      cap_idx_q     <= cap_idx_d;
      kernel_q      <= kernel_d;
      busy_q        <= busy_d;
      src_ready_q   <= src_ready_d;
      pixel_valid_q <= pixel_valid_d;
      pixel_q       <= pixel_d;
      soc_q         <= soc_d;
      eoc_q         <= eoc_d;
      solf_q        <= solf_d;
      eolf_q        <= eolf_d;
    end
  end

  assign px.src_ready       = src_ready_q;
  assign px.pixel_valid_out = pixel_valid_q;
  assign px.pixel_out       = pixel_q;
  assign px.soc_out         = soc_q;
  assign px.eoc_out         = eoc_q;
  assign px.solf_out        = solf_q;
  assign px.eolf_out        = eolf_q;
  assign px.kernel_size_out = kernel_q;
  assign px.capture_idx     = cap_idx_q;
  assign busy               = busy_q;

endmodule
